// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
// slave is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_data;
  logic              i_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              timeout_err;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ack,
    output i_data, i_ready,
    output d_rdata, d_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output timeout_err
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ack,
    input  i_data, i_ready,
    input  d_rdata, d_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one memory port.
// D has priority unless I was passed over right after a D access.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              last_d_q, last_d_d;
  logic              i_wait_q, i_wait_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_data_q, i_data_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_rdy_q, i_rdy_d;
  logic              d_rdy_q, d_rdy_d;
  logic              terr_q, terr_d;

  logic              i_act, d_act;
  logic              pick_i, pick_d;
  logic              expired;
  logic [DATA_W-1:0] rsp;

  // a requester in its ready cycle still shows its old req
  assign i_act   = bus.i_req & ~i_rdy_q;
  assign d_act   = bus.d_req & ~d_rdy_q;
  assign pick_i  = i_act & (~d_act | (last_d_q & i_wait_q));
  assign pick_d  = d_act & ~pick_i;
  assign expired = ~bus.mem_ack & (cnt_q == CNT_LAST);
  assign rsp     = bus.mem_ack ? bus.mem_rdata : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d_d    = last_d_q;
    i_wait_d    = i_wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_data_d    = i_data_q;
    d_rdata_d   = d_rdata_q;
    i_rdy_d     = 1'b0;
    d_rdy_d     = 1'b0;
    terr_d      = terr_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick_i: begin
            state_d     = BUSY_I;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = '0;
            i_wait_d    = 1'b0;
          end
          pick_d: begin
            state_d     = BUSY_D;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            if (bus.i_req) i_wait_d = 1'b1;
          end
          default: ;
        endcase
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack || expired) begin
          state_d   = IDLE;
          cnt_d     = '0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          last_d_d  = (state_q == BUSY_D);
          terr_d    = terr_q | expired;
          if (state_q == BUSY_D) begin
            d_rdata_d = rsp;
            d_rdy_d   = 1'b1;
          end else begin
            i_data_d = rsp;
            i_rdy_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_d_q    <= 1'b0;
      i_wait_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_data_q    <= '0;
      d_rdata_q   <= '0;
      i_rdy_q     <= 1'b0;
      d_rdy_q     <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_d_q    <= last_d_d;
      i_wait_q    <= i_wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_data_q    <= i_data_d;
      d_rdata_q   <= d_rdata_d;
      i_rdy_q     <= i_rdy_d;
      d_rdy_q     <= d_rdy_d;
      terr_q      <= terr_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.i_data      = i_data_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.i_ready     = i_rdy_q;
  assign bus.d_ready     = d_rdy_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(
    .ADDR_W (16),
    .DATA_W (16),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: who owns the port, how long it has waited
  typedef enum int {NONE, OWN_I, OWN_D} own_e;
  own_e        m_own;
  int          m_wait;
  bit          m_last_d, m_i_owed, m_ok = 0;
  logic        m_req, m_we, m_irdy, m_drdy, m_terr;
  logic [15:0] m_addr, m_wdata, m_idata, m_ddata, val;
  bit          want_i, want_d, fin;

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_mem_req", 32'(bus.mem_req), 32'(m_req));
      chk("m_mem_we", 32'(bus.mem_we), 32'(m_we));
      chk("m_mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      chk("m_mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
      chk("m_i_data", 32'(bus.i_data), 32'(m_idata));
      chk("m_d_rdata", 32'(bus.d_rdata), 32'(m_ddata));
      chk("m_i_ready", 32'(bus.i_ready), 32'(m_irdy));
      chk("m_d_ready", 32'(bus.d_ready), 32'(m_drdy));
      chk("m_terr", 32'(bus.timeout_err), 32'(m_terr));
    end
    if (reset === 1'b1) begin
      m_own = NONE; m_wait = 0; m_last_d = 0; m_i_owed = 0;
      m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_idata = 0; m_ddata = 0; m_irdy = 0; m_drdy = 0;
      m_terr = 0; m_ok = 1;
    end else if (m_ok) begin
      want_i = bus.i_req && !m_irdy;
      want_d = bus.d_req && !m_drdy;
      m_irdy = 0;
      m_drdy = 0;
      if (m_own == NONE) begin
        if (want_i && (!want_d || (m_last_d && m_i_owed))) begin
          m_own = OWN_I; m_wait = 0; m_req = 1; m_we = 0;
          m_addr = bus.i_addr; m_wdata = 0; m_i_owed = 0;
        end else if (want_d) begin
          m_own = OWN_D; m_wait = 0; m_req = 1; m_we = bus.d_we;
          m_addr = bus.d_addr; m_wdata = bus.d_wdata;
          if (bus.i_req) m_i_owed = 1;
        end
      end else begin
        fin = 0;
        val = 0;
        if (bus.mem_ack) begin
          fin = 1;
          val = bus.mem_rdata;
        end else if (m_wait + 1 >= TO) begin
          fin = 1;
          m_terr = 1;
        end else begin
          m_wait++;
        end
        if (fin) begin
          if (m_own == OWN_I) begin m_idata = val; m_irdy = 1; end
          else begin m_ddata = val; m_drdy = 1; end
          m_last_d = (m_own == OWN_D);
          m_own = NONE;
          m_req = 0;
          m_we = 0;
        end
      end
    end
  end

  task automatic xact(input string nm, input bit is_d, input bit we,
                      input logic [15:0] addr, input logic [15:0] wdata,
                      input int dly, input logic [15:0] rdata,
                      input logic [15:0] exp_data, input int exp_busy);
    int n;
    bit seen;
    if (is_d) begin
      bus.d_req = 1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1; bus.i_addr = addr;
    end
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      tick();
      seen = (bus.mem_req === 1'b1);
    end
    chk({nm, "_grant"}, 32'(seen), 32'd1);
    chk({nm, "_we"}, 32'(bus.mem_we), 32'(we));
    chk({nm, "_addr"}, 32'(bus.mem_addr), 32'(addr));
    chk({nm, "_wdata"}, 32'(bus.mem_wdata), is_d ? 32'(wdata) : 32'd0);
    n = 0;
    while (bus.mem_req === 1'b1 && n < 10) begin
      bus.mem_ack = (n == dly);
      bus.mem_rdata = (n == dly) ? rdata : 16'h0;
      n++;
      tick();
      bus.mem_ack = 0;
    end
    chk({nm, "_busy"}, 32'(n), 32'(exp_busy));
    chk({nm, "_rdy"}, 32'(is_d ? bus.d_ready : bus.i_ready), 32'd1);
    chk({nm, "_other"}, 32'(is_d ? bus.i_ready : bus.d_ready), 32'd0);
    chk({nm, "_data"}, 32'(is_d ? bus.d_rdata : bus.i_data),
        32'(exp_data));
    if (is_d) bus.d_req = 0;
    else bus.i_req = 0;
    tick();
    chk({nm, "_pulse"}, 32'(bus.i_ready | bus.d_ready), 32'd0);
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          dly;
    logic [15:0] rdata;
    logic [15:0] exp_data;
    int          exp_busy;
    bit          exp_terr;
  } vec_t;

  vec_t vt[6];
  bit   seen, i_hold, d_hold, mact;
  int   mwait, mdly;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vt[0] = '{0, 0, 16'h0010, 16'h0000, 1, 16'hBEEF, 16'hBEEF, 2, 0};
    vt[1] = '{1, 1, 16'h0200, 16'h1234, 0, 16'h5555, 16'h5555, 1, 0};
    vt[2] = '{1, 0, 16'h0ABC, 16'h0000, 2, 16'hCAFE, 16'hCAFE, 3, 0};
    vt[3] = '{0, 0, 16'hFFFF, 16'h0000, 3, 16'h0001, 16'h0001, 4, 0};
    vt[4] = '{1, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 1, 0};
    vt[5] = '{1, 0, 16'h0300, 16'h0000, 99, 16'h7777, 16'h0000, 4, 1};

    reset = 1;
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    tick();
    tick();
    reset = 0;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_i_data", 32'(bus.i_data), 32'd0);
    chk("rst_d_rdata", 32'(bus.d_rdata), 32'd0);
    chk("rst_ready", 32'({bus.i_ready, bus.d_ready}), 32'd0);
    chk("rst_terr", 32'(bus.timeout_err), 32'd0);

    for (int i = 0; i < 6; i++) begin
      xact($sformatf("v%0d", i), vt[i].is_d, vt[i].we, vt[i].addr,
           vt[i].wdata, vt[i].dly, vt[i].rdata, vt[i].exp_data,
           vt[i].exp_busy);
      chk($sformatf("v%0d_terr", i), 32'(bus.timeout_err),
          32'(vt[i].exp_terr));
    end

    // late ack after the watchdog fired
    bus.mem_ack = 1;
    bus.mem_rdata = 16'hDEAD;
    tick();
    bus.mem_ack = 0;
    chk("late_ack_rdy", 32'({bus.i_ready, bus.d_ready}), 32'd0);
    chk("late_ack_idata", 32'(bus.i_data), 32'h0001);
    chk("late_ack_ddata", 32'(bus.d_rdata), 32'h0000);
    chk("late_ack_req", 32'(bus.mem_req), 32'd0);
    tick();
    chk("terr_sticky", 32'(bus.timeout_err), 32'd1);

    // contention: D wins first, then strict alternation
    bus.i_addr = 16'h1111;
    bus.d_addr = 16'h2222;
    bus.d_we = 0;
    bus.i_req = 1;
    bus.d_req = 1;
    for (int k = 0; k < 4; k++) begin
      seen = 0;
      for (int w = 0; w < 6 && !seen; w++) begin
        tick();
        seen = (bus.mem_req === 1'b1);
      end
      chk($sformatf("cont%0d_grant", k), 32'(seen), 32'd1);
      chk($sformatf("cont%0d_addr", k), 32'(bus.mem_addr),
          (k % 2 == 0) ? 32'h2222 : 32'h1111);
      bus.mem_ack = 1;
      bus.mem_rdata = 16'(16'hA0 + k);
      tick();
      bus.mem_ack = 0;
      chk($sformatf("cont%0d_rdy", k), 32'({bus.i_ready, bus.d_ready}),
          (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k == 3) begin
        bus.i_req = 0;
        bus.d_req = 0;
      end
    end
    tick();
    chk("cont_idle", 32'(bus.mem_req), 32'd0);
    chk("cont_idata", 32'(bus.i_data), 32'hA3);
    chk("cont_ddata", 32'(bus.d_rdata), 32'hA2);

    // reset in the middle of a fetch
    bus.i_req = 1;
    bus.i_addr = 16'h0444;
    seen = 0;
    for (int w = 0; w < 6 && !seen; w++) begin
      tick();
      seen = (bus.mem_req === 1'b1);
    end
    chk("rmid_grant", 32'(seen), 32'd1);
    tick();
    reset = 1;
    bus.i_req = 0;
    tick();
    reset = 0;
    chk("rmid_req", 32'(bus.mem_req), 32'd0);
    chk("rmid_addr", 32'(bus.mem_addr), 32'd0);
    chk("rmid_data", 32'({bus.i_data, bus.d_rdata}), 32'd0);
    chk("rmid_terr", 32'(bus.timeout_err), 32'd0);
    xact("after_rst", 0, 0, 16'h0100, 16'h0, 0, 16'h4242, 16'h4242, 1);

    // random traffic, checked by the model each cycle
    i_hold = 0; d_hold = 0; mact = 0; mwait = 0; mdly = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(399) == 0);
      if (bus.i_ready) i_hold = 1;
      else if (i_hold) begin
        i_hold = 0;
        bus.i_req = ($urandom_range(1) == 1);
        bus.i_addr = 16'($urandom);
      end else if (!bus.i_req) begin
        if ($urandom_range(3) == 0) begin
          bus.i_req = 1;
          bus.i_addr = 16'($urandom);
        end
      end else if ($urandom_range(63) == 0) bus.i_req = 0;
      if (bus.d_ready) d_hold = 1;
      else if (d_hold) begin
        d_hold = 0;
        bus.d_req = ($urandom_range(1) == 1);
        bus.d_we = ($urandom_range(1) == 1);
        bus.d_addr = 16'($urandom);
        bus.d_wdata = 16'($urandom);
      end else if (!bus.d_req) begin
        if ($urandom_range(3) == 0) begin
          bus.d_req = 1;
          bus.d_we = ($urandom_range(1) == 1);
          bus.d_addr = 16'($urandom);
          bus.d_wdata = 16'($urandom);
        end
      end else if ($urandom_range(63) == 0) bus.d_req = 0;
      if (bus.mem_req) begin
        if (!mact) begin
          mact = 1;
          mwait = 0;
          mdly = $urandom_range(5);
        end
        bus.mem_ack = (mwait == mdly);
        mwait++;
      end else begin
        mact = 0;
        bus.mem_ack = ($urandom_range(7) == 0);
      end
      bus.mem_rdata = 16'($urandom);
      tick();
    end
    reset = 0;
    bus.i_req = 0;
    bus.d_req = 0;
    bus.mem_ack = 0;
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined CPU.
- Serialises the two requesters onto the memory request/ack handshake.
- Returns read data and a one-cycle ready pulse to each requester; the hazard/stall logic uses these to hold the pipeline.
- Includes a fairness rule and a watchdog, so a missing memory ack stalls the pipeline for a bounded time only.

Parameters:
- ADDR_W, 16, address width of both requesters and the memory port
- DATA_W, 16, data word width
- TIMEOUT, 255, max cycles waiting for mem_ack before forced completion; 1..(2^8-1)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  IF fetch request; level, held with i_addr stable until i_ready
- i_addr  in  ADDR_W  fetch address
- i_data  out  DATA_W  fetched word; valid in the i_ready cycle, held until next IF completion
- i_ready  out  1  one-cycle pulse: fetch complete
- d_req  in  1  MEM-stage request; level, held with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid in the d_ready cycle, held until next D completion
- d_ready  out  1  one-cycle pulse: data access complete; pulses for stores too
- mem_req  out  1  memory request; registered, held until the cycle after mem_ack
- mem_we  out  1  memory write enable; registered with mem_req
- mem_addr  out  ADDR_W  memory address; registered
- mem_wdata  out  DATA_W  memory write data; registered
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack = 1
- mem_ack  in  1  one-cycle memory completion pulse
- timeout_err  out  1  sticky; set on any watchdog expiry, cleared only by reset

Behaviour:
- Reset values:
  - state = IDLE; counter = 0; last_was_d = 0; i_waited = 0
  - mem_req/mem_we = 0; mem_addr/mem_wdata = 0
  - i_data/d_rdata = 0; i_ready/d_ready = 0; timeout_err = 0
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE grant rules, evaluated each cycle with i_ready = d_ready = 0:
  - only i_req: go to BUSY_I
  - only d_req: go to BUSY_D
  - both asserted: D wins, unless last_was_d = 1 and i_waited = 1, in which case I wins.
  - On a grant, latch addr/we/wdata into the mem_* registers and set mem_req = 1 from the next cycle. Grant-to-mem_req latency is 1 cycle.
  - A store granted to I is impossible; mem_we = 0 for every I grant.
- BUSY_x:
  - counter increments each cycle mem_ack = 0.
  - On mem_ack = 1:
    - mem_req = 0 next cycle
    - capture mem_rdata into x_data; pulse x_ready next cycle
    - set last_was_d = (x == D); return to IDLE
    - counter = 0
  - On counter reaching TIMEOUT without ack:
    - same completion path, with x_data = 0
    - set timeout_err
  - A mem_ack arriving after a timeout completion, while in IDLE, is ignored.
- i_waited:
  - set when a BUSY_D grant occurs while i_req = 1
  - cleared on any BUSY_I grant
- Back-to-back transactions:
  - The ready-pulse cycle is also an IDLE cycle.
  - A new grant may occur in it only for the *other* requester. The requester receiving ready must drop or re-present its req next cycle, so its stale req is ignored in the ready-pulse cycle.
  - Minimum per-access time, with ack in the first mem_req cycle, is 3 cycles: grant, mem_req/ack, ready.
- Requester drops req mid-transaction: the transaction still completes and the ready pulse is still issued (it may be ignored).
- mem_ack in IDLE: ignored; no output change.
- Reset mid-transaction: all outputs return to reset values on the next edge; the in-flight memory access is abandoned, and the memory tolerates this.
- Each ready pulse is exactly 1 cycle; i_ready and d_ready are never asserted in the same cycle.

Test Plan:
- Single fetch: i_req = 1, i_addr = 0x0010; memory acks 2 cycles after mem_req with 0xBEEF -> mem_req high for 2 cycles, mem_we = 0, then i_ready pulse with i_data = 0xBEEF; d_ready stays 0.
- Store: d_req = 1, d_we = 1, d_addr = 0x0200, d_wdata = 0x1234 -> mem_we = 1, mem_addr = 0x0200, mem_wdata = 0x1234; d_ready pulses once after ack.
- Contention and fairness: i_req and d_req both held continuously, each re-asserted after its ready -> grant order D, I, D, I; neither side waits more than one foreign transaction.
- Watchdog: TIMEOUT = 4, d_req load, mem_ack never asserted -> d_ready pulses after 4 busy cycles with d_rdata = 0; timeout_err = 1 and stays 1; a late mem_ack is ignored.
- Reset mid-access: in BUSY_I after 1 cycle of mem_req, assert reset for 1 cycle -> next cycle mem_req = 0, all outputs 0, state IDLE; a later fetch completes normally.
- Stray ack: mem_ack pulsed while IDLE with no requests -> no ready pulse, i_data/d_rdata unchanged.
